// File: rtl/case1_pkg.sv
// Shared definitions for the six-source select multiplexer.
//   SEL_W  : select code width
//   N_SRC  : number of legal data sources (codes 0..N_SRC-1)
//   DATA_W : default data width
//   sel_e  : names for the legal select codes
package case1_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned N_SRC  = 6;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [SEL_W-1:0] {
    SEL_D0 = 3'd0,
    SEL_D1 = 3'd1,
    SEL_D2 = 3'd2,
    SEL_D3 = 3'd3,
    SEL_D4 = 3'd4,
    SEL_D5 = 3'd5
  } sel_e;

endpackage

// File: rtl/case1_sel_mux.sv
// Six-input, WIDTH-bit select multiplexer with a registered copy of the result.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (clears out_q only)
//   sel      : select code, 0..5 legal, 6..7 illegal
//   data0..5 : data sources
//   out      : combinational selection (DEF_VAL for illegal/unknown sel)
//   out_q    : out registered on clk
//   sel_err  : combinational, high when sel is 6 or 7
module case1_sel_mux
  import case1_pkg::*;
#(
  parameter int unsigned      WIDTH   = DATA_W,
  parameter logic [WIDTH-1:0] DEF_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic [WIDTH-1:0] data4,
  input  logic [WIDTH-1:0] data5,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_err
);

  // An X/Z select matches no item and falls to the default, so unknowns
  // never reach out or the register.
  always_comb begin
    out = DEF_VAL;
    case (sel)
      SEL_D0:  out = data0;
      SEL_D1:  out = data1;
      SEL_D2:  out = data2;
      SEL_D3:  out = data3;
      SEL_D4:  out = data4;
      SEL_D5:  out = data5;
      default: out = DEF_VAL;
    endcase
    sel_err = (sel > SEL_W'(N_SRC - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out;
  end

endmodule

// File: tb/tb_case1_sel_mux.sv
module tb_case1_sel_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sel;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic [3:0] out, out_q;
  logic       sel_err;

  logic [2:0] sel8;
  logic [7:0] w0, w1, w2, w3, w4, w5;
  logic [7:0] out8, out_q8;
  logic       sel_err8;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  case1_sel_mux u_dut (
    .clk(clk), .rst(rst), .sel(sel),
    .data0(d0), .data1(d1), .data2(d2), .data3(d3), .data4(d4), .data5(d5),
    .out(out), .out_q(out_q), .sel_err(sel_err)
  );

  case1_sel_mux #(.WIDTH(8), .DEF_VAL(8'h5A)) u_dut8 (
    .clk(clk), .rst(rst), .sel(sel8),
    .data0(w0), .data1(w1), .data2(w2), .data3(w3), .data4(w4), .data5(w5),
    .out(out8), .out_q(out_q8), .sel_err(sel_err8)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [3:0] exp_out [8];
  logic       exp_err [8];
  logic [3:0] exp_x;

  initial begin
    exp_out = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'h0, 4'h0};
    exp_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    sel = 3'd0;
    d0 = 4'h8; d1 = 4'h9; d2 = 4'hA; d3 = 4'hB; d4 = 4'hC; d5 = 4'hD;
    sel8 = 3'd0;
    w0 = 8'h10; w1 = 8'h21; w2 = 8'hA5; w3 = 8'h43; w4 = 8'h54; w5 = 8'h65;

    // Reset state, then reset must not gate the combinational path.
    #2;
    check("reset_out_q", out_q, 4'h0);
    check("reset_out_q8", out_q8, 8'h00);
    check("reset_out_live", out, 4'h8);
    @(posedge clk); #1;
    check("reset_hold_out_q", out_q, 4'h0);

    @(negedge clk);
    rst = 1'b0;

    // 1. Sweep all select codes.
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #1;
      check($sformatf("sweep_out_%0d", i), out, exp_out[i]);
      check($sformatf("sweep_err_%0d", i), 8'(sel_err), 8'(exp_err[i]));
      #4;
    end

    // 2. Registered path: data change mid-cycle.
    @(negedge clk);
    sel = 3'd3; d3 = 4'hA;
    @(posedge clk); #1;
    check("reg_load_A", out_q, 4'hA);
    @(negedge clk);
    d3 = 4'hB;
    #1;
    check("reg_out_instant", out, 4'hB);
    check("reg_out_q_held", out_q, 4'hA);
    @(posedge clk); #1;
    check("reg_out_q_B", out_q, 4'hB);

    // 3. Asynchronous reset between edges.
    @(negedge clk);
    sel = 3'd4;
    @(posedge clk); #1;
    check("pre_rst_out_q_C", out_q, 4'hC);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_q", out_q, 4'h0);
    check("async_rst_out", out, 4'hC);
    check("async_rst_sel_err", 8'(sel_err), 8'h00);
    @(posedge clk); #1;
    check("rst_held_out_q", out_q, 4'h0);

    // 4. Reset release: first edge loads current out.
    @(negedge clk);
    sel = 3'd5; d5 = 4'hD;
    rst = 1'b0;
    #1;
    check("release_out_q_0", out_q, 4'h0);
    check("release_out", out, 4'hD);
    @(posedge clk); #1;
    check("release_out_q_D", out_q, 4'hD);

    // 5. Unknown select: DEF_VAL in 4-state, a legal code if X is resolved.
    @(negedge clk);
    sel = 3'bx1x;
    #1;
    if ($isunknown(sel)) exp_x = 4'h0;
    else                 exp_x = exp_out[sel];
    check("xsel_out", out, exp_x);
    @(posedge clk); #1;
    check("xsel_out_q_known", 8'($isunknown(out_q)), 8'h00);
    check("xsel_out_q", out_q, exp_x);

    // 6. Wide instance with non-zero DEF_VAL.
    @(negedge clk);
    sel8 = 3'd2;
    #1;
    check("w8_out", out8, 8'hA5);
    @(posedge clk); #1;
    check("w8_out_q", out_q8, 8'hA5);
    @(negedge clk);
    sel8 = 3'd7;
    #1;
    check("w8_def_val", out8, 8'h5A);
    check("w8_sel_err", 8'(sel_err8), 8'h01);
    sel8 = 3'd5;
    #1;
    check("w8_sel5", out8, 8'h65);
    check("w8_sel5_err", 8'(sel_err8), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
